// File: rtl/mem_copy_loader_if.sv
// Purpose: mem_copy port bundle between the ioctl loader (master) and the memory block (slave).
// Latency: none, wires only.
// Backpressure: none; the master owns timing through fixed-length we/rd pulses.
// Signals: mem_copy (session owns memory), mem_copy_virt (CPU virtual address),
//          mem_copy_addr (word-aligned byte address), mem_copy_din (write word),
//          mem_copy_dout (read word), mem_copy_we / mem_copy_rd (write / read pulses).
interface mem_copy_loader_if;
    logic        mem_copy;
    logic        mem_copy_virt;
    logic [24:0] mem_copy_addr;
    logic [15:0] mem_copy_din;
    logic [15:0] mem_copy_dout;
    logic        mem_copy_we;
    logic        mem_copy_rd;

    modport master (
        output mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_din, mem_copy_we, mem_copy_rd,
        input  mem_copy_dout
    );

    modport slave (
        input  mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_din, mem_copy_we, mem_copy_rd,
        output mem_copy_dout
    );
endinterface

// File: rtl/mem_copy_loader.sv
// Purpose: bridges the byte-wide host ioctl channel to 16-bit mem_copy word writes/reads.
// Latency: write pulse starts 2 cycles after the completing byte; upload byte valid RD_CYCLES+2 (even) / 1 (odd) cycles after ioctl_rd.
// Backpressure: none toward the host; one pending word is buffered, further words are dropped and flagged in overflow.
// Ports: clk_sys/reset (sync, active-high); ioctl_* host download/upload channel;
//        mc (mem_copy master bundle); busy (engine active or word pending); overflow (sticky word loss).
module mem_copy_loader #(
    parameter int WE_CYCLES  = 4,
    parameter int RD_CYCLES  = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic                     ioctl_upload,
    input  logic [7:0]               ioctl_index,
    input  logic [24:0]              ioctl_addr,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_dout,
    input  logic                     ioctl_rd,
    output logic [7:0]               ioctl_din,
    mem_copy_loader_if.master        mc,
    output logic                     busy,
    output logic                     overflow
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WGAP  = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_RGAP  = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state;
    logic [7:0]  cnt;

    logic        dl_q, ul_q;
    logic        end_req;
    logic        idx_ok;

    logic        copy_q, virt_q, we_q, rd_q;
    logic [24:0] addr_q;
    logic [15:0] din_q;

    // byte assembly: held low byte and the word it belongs to
    logic        half;
    logic [7:0]  lo_byte;
    logic [23:0] asm_addr;

    // single-entry pending word
    logic        pend_vld;
    logic [23:0] pend_addr;
    logic [15:0] pend_din;

    // upload side
    logic        rd_req;
    logic [23:0] rd_req_addr;
    logic [15:0] rd_latch;
    logic        din_upd;

    logic        dl_start, ul_start, sess_start, idx_eff;
    logic        byte_wr, rd_strobe, rd_even, rd_odd;
    logic        same_word, pop, rd_take_now;
    logic        nw_vld, nw_lost;
    logic [23:0] nw_addr;
    logic [15:0] nw_din;

    assign dl_start   = ioctl_download & ~dl_q;
    assign ul_start   = ioctl_upload & ~ul_q;
    assign sess_start = dl_start | ul_start;
    // a strobe in the very first session cycle must see the new index, not the stale latch
    assign idx_eff    = sess_start ? (ioctl_index <= 8'd1) : idx_ok;

    assign byte_wr    = ioctl_download & ioctl_wr & idx_eff;
    // download wins: upload strobes are ignored while a download is active
    assign rd_strobe  = ioctl_upload & ~ioctl_download & ioctl_rd & idx_eff;
    assign rd_even    = rd_strobe & ~ioctl_addr[0];
    assign rd_odd     = rd_strobe & ioctl_addr[0];

    assign same_word  = half & (asm_addr == ioctl_addr[24:1]);
    assign pop        = (state == S_IDLE) & pend_vld;
    assign rd_take_now = (state == S_IDLE) & ~pend_vld & ~rd_req;

    // word completion from the byte stream
    always_comb begin
        nw_vld  = 1'b0;
        nw_lost = 1'b0;
        nw_addr = asm_addr;
        nw_din  = {8'h00, lo_byte};
        if (byte_wr) begin
            if (ioctl_addr[0]) begin
                nw_vld  = 1'b1;
                nw_addr = ioctl_addr[24:1];
                nw_din  = {ioctl_dout, same_word ? lo_byte : 8'h00};
                // an odd byte cannot also flush a stale half-word in the same cycle
                nw_lost = half & ~same_word;
            end else if (half && !same_word) begin
                // stale half-word is closed out with a zero high byte
                nw_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dl_q        <= 1'b0;
            ul_q        <= 1'b0;
            end_req     <= 1'b0;
            idx_ok      <= 1'b0;
            copy_q      <= 1'b0;
            virt_q      <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            half        <= 1'b0;
            lo_byte     <= '0;
            asm_addr    <= '0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
            pend_din    <= '0;
            rd_req      <= 1'b0;
            rd_req_addr <= '0;
            rd_latch    <= '0;
            din_upd     <= 1'b0;
            ioctl_din   <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            ul_q <= ioctl_upload;
            if ((dl_q & ~ioctl_download) | (ul_q & ~ioctl_upload))
                end_req <= 1'b1;

            if (byte_wr) begin
                if (ioctl_addr[0]) begin
                    half <= 1'b0;
                end else begin
                    half     <= 1'b1;
                    lo_byte  <= ioctl_dout;
                    asm_addr <= ioctl_addr[24:1];
                end
            end

            if (pop)
                pend_vld <= 1'b0;
            if (nw_vld) begin
                if (!pend_vld || pop) begin
                    pend_vld  <= 1'b1;
                    pend_addr <= nw_addr;
                    pend_din  <= nw_din;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (nw_lost)
                overflow <= 1'b1;

            if (rd_odd)
                ioctl_din <= rd_latch[15:8];
            if (din_upd) begin
                ioctl_din <= rd_latch[7:0];
                din_upd   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend_vld) begin
                        addr_q <= {pend_addr, 1'b0};
                        din_q  <= pend_din;
                        cnt    <= '0;
                        state  <= S_WR;
                    end else if (rd_req || rd_even) begin
                        // oldest request first
                        addr_q <= {rd_req ? rd_req_addr : ioctl_addr[24:1], 1'b0};
                        rd_req <= 1'b0;
                        rd_q   <= 1'b1;
                        cnt    <= '0;
                        state  <= S_RD;
                    end else if (end_req) begin
                        state <= half ? S_FLUSH : S_DONE;
                    end
                end
                S_WR: begin
                    // first WR cycle keeps we low so the memory sees a clean rising edge
                    if (cnt == 8'(WE_CYCLES)) begin
                        we_q  <= 1'b0;
                        cnt   <= '0;
                        state <= S_WGAP;
                    end else begin
                        we_q <= 1'b1;
                        cnt  <= cnt + 8'd1;
                    end
                end
                S_RD: begin
                    if (cnt == 8'(RD_CYCLES - 1)) begin
                        rd_q     <= 1'b0;
                        rd_latch <= mc.mem_copy_dout;
                        din_upd  <= 1'b1;
                        cnt      <= '0;
                        state    <= S_RGAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_WGAP, S_RGAP: begin
                    if (cnt == 8'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    // only entered with the pending register empty
                    pend_vld  <= 1'b1;
                    pend_addr <= asm_addr;
                    pend_din  <= {8'h00, lo_byte};
                    half      <= 1'b0;
                    state     <= S_IDLE;
                end
                S_DONE: begin
                    copy_q  <= 1'b0;
                    virt_q  <= 1'b0;
                    idx_ok  <= 1'b0;
                    end_req <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // strobes arriving while the engine is busy wait here; placed after the case so a new one survives a take
            if (rd_even && !rd_take_now) begin
                rd_req      <= 1'b1;
                rd_req_addr <= ioctl_addr[24:1];
            end

            if (sess_start) begin
                copy_q <= 1'b1;
                virt_q <= (ioctl_index == 8'd1);
                idx_ok <= (ioctl_index <= 8'd1);
            end
        end
    end

    assign mc.mem_copy      = copy_q;
    assign mc.mem_copy_virt = virt_q;
    assign mc.mem_copy_addr = addr_q;
    assign mc.mem_copy_din  = din_q;
    assign mc.mem_copy_we   = we_q;
    assign mc.mem_copy_rd   = rd_q;

    assign busy = (state != S_IDLE) | pend_vld;

endmodule

// File: tb/tb_mem_copy_loader.sv
module tb_mem_copy_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
    logic [7:0]  ioctl_index, ioctl_dout, ioctl_din;
    logic [24:0] ioctl_addr;
    logic        busy, overflow;
    logic [15:0] mem_dout;

    mem_copy_loader_if mc();
    assign mc.mem_copy_dout = mem_dout;

    mem_copy_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_rd       (ioctl_rd),
        .ioctl_din      (ioctl_din),
        .mc             (mc),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] din;
        logic        virt;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [24:0] rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic push_wr(input logic [24:0] a, input logic [15:0] d, input logic v);
        wr_exp_t e;
        e.addr = a;
        e.din  = d;
        e.virt = v;
        wr_q.push_back(e);
    endtask

    task automatic wait_session_end(input string name);
        int k = 0;
        while (mc.mem_copy && k < 300) begin
            step(1);
            k++;
        end
        check({name, "_copy_drop"}, 32'(mc.mem_copy), 32'd0);
        check({name, "_virt_drop"}, 32'(mc.mem_copy_virt), 32'd0);
        check({name, "_writes_drained"}, 32'(wr_q.size()), 32'd0);
    endtask

    // monitor: pops the scoreboard whenever a we/rd pulse completes
    logic        we_prev = 1'b0, rd_prev = 1'b0;
    int          we_len = 0, rd_len = 0;
    logic [24:0] we_addr, rd_addr;
    logic [15:0] we_din;
    logic        we_virt;

    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                we_prev = 1'b0;
                rd_prev = 1'b0;
                we_len  = 0;
                rd_len  = 0;
            end else begin
                if (mc.mem_copy_we || mc.mem_copy_rd) begin
                    check("we_rd_exclusive", 32'(mc.mem_copy_we & mc.mem_copy_rd), 32'd0);
                    check("pulse_inside_copy", 32'(mc.mem_copy), 32'd1);
                end
                if (mc.mem_copy_we && !we_prev) begin
                    we_addr = mc.mem_copy_addr;
                    we_din  = mc.mem_copy_din;
                    we_virt = mc.mem_copy_virt;
                    we_len  = 1;
                end else if (mc.mem_copy_we) begin
                    we_len++;
                end
                if (!mc.mem_copy_we && we_prev) begin
                    n_wr_seen++;
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, expected no write", we_addr, we_din);
                    end else begin
                        wr_exp_t e;
                        e = wr_q.pop_front();
                        check("wr_addr", 32'(we_addr), 32'(e.addr));
                        check("wr_din", 32'(we_din), 32'(e.din));
                        check("wr_virt", 32'(we_virt), 32'(e.virt));
                        check("wr_len", 32'(we_len), 32'd4);
                    end
                end
                if (mc.mem_copy_rd && !rd_prev) begin
                    rd_addr = mc.mem_copy_addr;
                    rd_len  = 1;
                end else if (mc.mem_copy_rd) begin
                    rd_len++;
                end
                if (!mc.mem_copy_rd && rd_prev) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_read: addr 0x%0h, expected no read", rd_addr);
                    end else begin
                        logic [24:0] ea;
                        ea = rd_q.pop_front();
                        check("rd_addr", 32'(rd_addr), 32'(ea));
                        check("rd_len", 32'(rd_len), 32'd6);
                    end
                end
                we_prev = mc.mem_copy_we;
                rd_prev = mc.mem_copy_rd;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'h00;
        ioctl_rd       = 1'b0;
        mem_dout       = 16'h0000;
        step(3);
        reset = 1'b0;
        step(1);

        // reset state
        check("rst_copy", 32'(mc.mem_copy), 32'd0);
        check("rst_we", 32'(mc.mem_copy_we), 32'd0);
        check("rst_rd", 32'(mc.mem_copy_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_din", 32'(ioctl_din), 32'd0);

        // physical image, one word
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        step(1);
        check("t1_copy_up", 32'(mc.mem_copy), 32'd1);
        check("t1_virt", 32'(mc.mem_copy_virt), 32'd0);
        push_wr(25'hE0000, 16'h1234, 1'b0);
        wr_byte(25'hE0000, 8'h34);
        wr_byte(25'hE0001, 8'h12);
        step(2);
        ioctl_download = 1'b0;
        wait_session_end("t1");

        // virtual .bin, odd byte count triggers flush
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        step(1);
        check("t2_virt", 32'(mc.mem_copy_virt), 32'd1);
        push_wr(25'h1000, 16'hBBAA, 1'b1);
        push_wr(25'h1002, 16'h00CC, 1'b1);
        wr_byte(25'h1000, 8'hAA);
        wr_byte(25'h1001, 8'hBB);
        wr_byte(25'h1002, 8'hCC);
        ioctl_download = 1'b0;
        wait_session_end("t2");

        // upload: even read issues a pulse, odd read reuses the latch
        ioctl_index  = 8'd0;
        mem_dout     = 16'hBEEF;
        ioctl_upload = 1'b1;
        step(1);
        rd_q.push_back(25'h20);
        ioctl_addr = 25'h20;
        ioctl_rd   = 1'b1;
        step(1);
        ioctl_rd   = 1'b0;
        step(6);
        check("t3_din_not_early", 32'(ioctl_din), 32'h00);
        step(1);
        check("t3_din_even", 32'(ioctl_din), 32'hEF);
        mem_dout   = 16'h1234;
        step(2);
        ioctl_addr = 25'h21;
        ioctl_rd   = 1'b1;
        step(1);
        ioctl_rd   = 1'b0;
        check("t3_din_odd", 32'(ioctl_din), 32'hBE);
        step(10);
        check("t3_reads_drained", 32'(rd_q.size()), 32'd0);
        ioctl_upload = 1'b0;
        wait_session_end("t3");

        // overflow: three words back to back, third dropped
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        step(1);
        push_wr(25'h100, 16'h1100, 1'b0);
        push_wr(25'h102, 16'h3322, 1'b0);
        wr_byte(25'h100, 8'h00);
        wr_byte(25'h101, 8'h11);
        wr_byte(25'h102, 8'h22);
        wr_byte(25'h103, 8'h33);
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        wr_byte(25'h104, 8'h44);
        wr_byte(25'h105, 8'h55);
        check("t4_overflow_set", 32'(overflow), 32'd1);
        ioctl_download = 1'b0;
        wait_session_end("t4");
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // reset in the second WR cycle aborts without a flush write
        ioctl_download = 1'b1;
        step(1);
        seen = n_wr_seen;
        wr_byte(25'h200, 8'h77);
        wr_byte(25'h201, 8'h66);
        step(2);
        check("t5_we_before_reset", 32'(mc.mem_copy_we), 32'd1);
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        step(1);
        check("t5_we_after_reset", 32'(mc.mem_copy_we), 32'd0);
        check("t5_copy_after_reset", 32'(mc.mem_copy), 32'd0);
        check("t5_busy_after_reset", 32'(busy), 32'd0);
        check("t5_overflow_cleared", 32'(overflow), 32'd0);
        reset = 1'b0;
        step(20);
        check("t5_no_flush_write", 32'(n_wr_seen), 32'(seen));

        // ignored index: session held but no pulses
        ioctl_index    = 8'd5;
        ioctl_download = 1'b1;
        step(1);
        check("t6_copy_up", 32'(mc.mem_copy), 32'd1);
        seen = n_wr_seen;
        wr_byte(25'h300, 8'h01);
        wr_byte(25'h301, 8'h02);
        wr_byte(25'h302, 8'h03);
        wr_byte(25'h303, 8'h04);
        step(12);
        check("t6_copy_held", 32'(mc.mem_copy), 32'd1);
        ioctl_download = 1'b0;
        wait_session_end("t6");
        check("t6_no_writes", 32'(n_wr_seen), 32'(seen));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
